// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared key ids, state encoding and default field widths for the note walker
package note_pkg;

  localparam int XW_DEF  = 8;
  localparam int YW_DEF  = 8;
  localparam int IDW_DEF = 2;

  localparam logic [1:0] KEY_A = 2'd0;
  localparam logic [1:0] KEY_S = 2'd1;
  localparam logic [1:0] KEY_D = 2'd2;
  localparam logic [1:0] KEY_F = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_lat_counter.sv
// rtl/rom_lat_counter.sv - counts 0..READ_LAT while enabled, saturating, with terminal-count flag
module rom_lat_counter #(
  parameter int READ_LAT = 1,
  parameter int CW       = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(READ_LAT));

endmodule

// File: rtl/note_loc_sequencer.sv
// rtl/note_loc_sequencer.sv - walks a DEPTH-entry note table in external ROMs and presents
// latency-aligned X/Y/key triples to the drawing FSM over a valid/advance handshake
module note_loc_sequencer
  import note_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 5,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int IDW      = IDW_DEF,
  parameter int READ_LAT = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           loop_en,
  input  logic           clear,
  input  logic           advance,
  output logic [AW-1:0]  rom_addr,
  input  logic [XW-1:0]  rom_x,
  input  logic [YW-1:0]  rom_y,
  input  logic [IDW-1:0] rom_id,
  output logic           out_valid,
  output logic [XW-1:0]  locx,
  output logic [YW-1:0]  locy,
  output logic [IDW-1:0] key_id,
  output logic [AW-1:0]  index,
  output logic           busy,
  output logic           done
);

  if ((64'd1 << AW) < 64'(DEPTH) || DEPTH < 2) begin : g_depth_check
    $error("note_loc_sequencer: DEPTH must be >= 2 and fit in AW address bits");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_lat_check
    $error("note_loc_sequencer: READ_LAT must be in 1..4");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            load;
  logic            lat_tc;

  // Counter sits at zero outside FETCH so every fetch starts a fresh latency window.
  rom_lat_counter #(
    .READ_LAT (READ_LAT),
    .CW       (3)
  ) u_lat (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != ST_FETCH),
    .en    (state_q == ST_FETCH),
    .tc    (lat_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      locx    <= '0;
      locy    <= '0;
      key_id  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      if (load) begin
        locx   <= rom_x;
        locy   <= rom_y;
        key_id <= rom_id;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    load    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx_d   = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (lat_tc) begin
            load    = 1'b1;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              if (loop_en) begin
                idx_d   = '0;
                state_d = ST_FETCH;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              idx_d   = idx_q + AW'(1);
              state_d = ST_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rom_addr  = idx_q;
  assign index     = idx_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_HOLD);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_loc_sequencer.sv
// tb/tb_note_loc_sequencer.sv - directed, table-driven bench for note_loc_sequencer
module tb_note_loc_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, loop_en, clear, advance;
  logic [2:0] rom_addr, index;
  logic [7:0] rom_x, rom_y, locx, locy;
  logic [1:0] rom_id, key_id;
  logic       out_valid, busy, done;

  logic       start1;
  logic       loop1  = 1'b0;
  logic       clear1 = 1'b0;
  logic       adv1   = 1'b1;
  logic [2:0] rom_addr1, index1;
  logic [7:0] rom_x1, rom_y1, locx1, locy1;
  logic [1:0] rom_id1, key_id1;
  logic       valid1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  note_loc_sequencer #(
    .DEPTH(4), .AW(3), .XW(8), .YW(8), .IDW(2), .READ_LAT(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .loop_en(loop_en), .clear(clear),
    .advance(advance), .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y), .rom_id(rom_id),
    .out_valid(out_valid), .locx(locx), .locy(locy), .key_id(key_id), .index(index),
    .busy(busy), .done(done)
  );

  note_loc_sequencer #(
    .DEPTH(4), .AW(3), .XW(8), .YW(8), .IDW(2), .READ_LAT(1)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1), .loop_en(loop1), .clear(clear1),
    .advance(adv1), .rom_addr(rom_addr1), .rom_x(rom_x1), .rom_y(rom_y1), .rom_id(rom_id1),
    .out_valid(valid1), .locx(locx1), .locy(locy1), .key_id(key_id1), .index(index1),
    .busy(busy1), .done(done1)
  );

  // Table entry i: X = 10*(i+1), Y = 100+i, id = i%4; entries 4..7 lie beyond DEPTH.
  logic [17:0] rom_mem [8];
  logic [17:0] p_a, p_b, p_c, q_a;

  always @(posedge clock) begin
    p_a <= rom_mem[rom_addr];
    p_b <= p_a;
    p_c <= p_b;
    q_a <= rom_mem[rom_addr1];
  end
  assign {rom_x, rom_y, rom_id}    = p_c;
  assign {rom_x1, rom_y1, rom_id1} = q_a;

  typedef struct {
    logic       le;
    logic [2:0] idx;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] id;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(out_valid), 1);
  endtask

  task automatic accept();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) rom_mem[i] = {8'(10 * (i + 1)), 8'(100 + i), 2'(i % 4)};
    vecs[0] = '{1'b0, 3'd0, 8'd10, 8'd100, 2'd0};
    vecs[1] = '{1'b0, 3'd1, 8'd20, 8'd101, 2'd1};
    vecs[2] = '{1'b0, 3'd2, 8'd30, 8'd102, 2'd2};
    vecs[3] = '{1'b1, 3'd3, 8'd40, 8'd103, 2'd3};
    vecs[4] = '{1'b1, 3'd0, 8'd10, 8'd100, 2'd0};
    vecs[5] = '{1'b1, 3'd1, 8'd20, 8'd101, 2'd1};
    vecs[6] = '{1'b1, 3'd2, 8'd30, 8'd102, 2'd2};
    vecs[7] = '{1'b0, 3'd3, 8'd40, 8'd103, 2'd3};

    reset = 1'b1; start = 1'b0; loop_en = 1'b0; clear = 1'b0; advance = 1'b0; start1 = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_index", 32'(index), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_locx", 32'(locx), 0);
    check("rst_locy", 32'(locy), 0);
    check("rst_key", 32'(key_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid1", 32'(valid1), 0);
    reset = 1'b0;
    tick();

    // Latency alignment and loop wrap: READ_LAT=3, one entry per 5 clocks.
    start = 1'b1;
    advance = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 8; r++) begin
      check("tbl_fetch_valid", 32'(out_valid), 0);
      check("tbl_fetch_busy", 32'(busy), 1);
      check("tbl_fetch_done", 32'(done), 0);
      check("tbl_fetch_addr", 32'(rom_addr), 32'(vecs[r].idx));
      for (int k = 0; k < 3; k++) begin
        tick();
        check("tbl_lat_valid", 32'(out_valid), 0);
      end
      tick();
      check("tbl_valid", 32'(out_valid), 1);
      check("tbl_index", 32'(index), 32'(vecs[r].idx));
      check("tbl_locx", 32'(locx), 32'(vecs[r].x));
      check("tbl_locy", 32'(locy), 32'(vecs[r].y));
      check("tbl_key", 32'(key_id), 32'(vecs[r].id));
      loop_en = vecs[r].le;
      tick();
    end
    advance = 1'b0;
    check("tbl_done", 32'(done), 1);
    check("tbl_end_valid", 32'(out_valid), 0);
    check("tbl_end_busy", 32'(busy), 0);
    check("tbl_end_locx", 32'(locx), 40);

    // Basic pass on the READ_LAT=1 instance: one entry per 3 clocks.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int e = 0; e < 4; e++) begin
      check("b1_fetch_valid", 32'(valid1), 0);
      tick();
      check("b1_lat_valid", 32'(valid1), 0);
      tick();
      check("b1_valid", 32'(valid1), 1);
      check("b1_index", 32'(index1), 32'(e));
      check("b1_locx", 32'(locx1), 32'(10 * (e + 1)));
      check("b1_done_low", 32'(done1), 0);
      tick();
    end
    check("b1_done", 32'(done1), 1);
    check("b1_end_valid", 32'(valid1), 0);

    // Backpressure at index 2, restarting from DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_done_fall", 32'(done), 0);
    check("bp_busy", 32'(busy), 1);
    wait_valid("bp_wait0");
    check("bp_idx0", 32'(index), 0);
    accept();
    wait_valid("bp_wait1");
    accept();
    wait_valid("bp_wait2");
    check("bp_idx2", 32'(index), 2);
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      tick();
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_index", 32'(index), 2);
      check("bp_hold_locx", 32'(locx), 30);
      check("bp_hold_locy", 32'(locy), 102);
      check("bp_hold_key", 32'(key_id), 2);
    end
    start = 1'b0;
    accept();
    check("bp_adv_valid", 32'(out_valid), 0);
    check("bp_adv_index", 32'(index), 3);
    wait_valid("bp_wait3");
    check("bp_idx3_locx", 32'(locx), 40);
    loop_en = 1'b0;
    accept();
    check("bp_done", 32'(done), 1);

    // clear beats start in DONE.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clr_start_done", 32'(done), 0);
    check("clr_start_busy", 32'(busy), 0);
    check("clr_start_valid", 32'(out_valid), 0);
    tick();
    check("clr_start_nofetch", 32'(busy), 0);

    // clear beats advance in HOLD; the presented fields are kept.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("ca_wait0");
    accept();
    wait_valid("ca_wait1");
    check("ca_idx1", 32'(index), 1);
    clear = 1'b1;
    advance = 1'b1;
    tick();
    clear = 1'b0;
    advance = 1'b0;
    check("ca_valid", 32'(out_valid), 0);
    check("ca_index", 32'(index), 0);
    check("ca_addr", 32'(rom_addr), 0);
    check("ca_busy", 32'(busy), 0);
    check("ca_locx_kept", 32'(locx), 20);

    // Asynchronous reset in the middle of fetching index 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("ar_wait0");
    accept();
    wait_valid("ar_wait1");
    accept();
    check("ar_pre_index", 32'(index), 2);
    check("ar_pre_busy", 32'(busy), 1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_valid", 32'(out_valid), 0);
    check("ar_index", 32'(index), 0);
    check("ar_addr", 32'(rom_addr), 0);
    check("ar_locx", 32'(locx), 0);
    check("ar_locy", 32'(locy), 0);
    check("ar_key", 32'(key_id), 0);
    check("ar_done", 32'(done), 0);
    #1;
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("ar_restart");
    check("ar_restart_index", 32'(index), 0);
    check("ar_restart_locx", 32'(locx), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_loc_sequencer.md
Name: note_loc_sequencer

Overview:
- Parametrised successor to the fixed 16-entry note-location walker.
- Steps through a DEPTH-entry note table held in external synchronous ROMs: X coordinate, Y coordinate and key id.
- Compensates for a configurable ROM read latency, so the three output fields always belong to the same table index.
- Presents each entry to the note-drawing FSM over a valid/advance handshake; supports one-shot and looping playback, plus a synchronous abort.

Parameters:
- DEPTH, 16, number of table entries (≥2)
- AW, 5, ROM address width; requires 2^AW ≥ DEPTH
- XW, 8, X coordinate width
- YW, 8, Y coordinate width
- IDW, 2, key id width (A/S/D/F = 0..3)
- READ_LAT, 1, ROM read latency in clocks (1..4)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a pass from index 0; honoured only in IDLE or DONE
- loop_en  in  1  when 1, wrap to index 0 after the last entry instead of finishing
- clear  in  1  synchronous abort to IDLE; has priority over all other inputs
- advance  in  1  consumer accepts the current entry
- rom_addr  out  AW  address driven to all three ROMs
- rom_x  in  XW  X ROM data, valid READ_LAT clocks after rom_addr
- rom_y  in  YW  Y ROM data
- rom_id  in  IDW  key-id ROM data
- out_valid  out  1  locx/locy/key_id/index are valid
- locx  out  XW  registered X coordinate
- locy  out  YW  registered Y coordinate
- key_id  out  IDW  registered key id
- index  out  AW  table index of the presented entry
- busy  out  1  high in FETCH or HOLD
- done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, rom_addr=0, index=0, locx=0, locy=0, key_id=0, out_valid=0, busy=0, done=0, latency counter=0.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - start=1 → rom_addr=0, index=0, latency counter=0, go to FETCH.
- FETCH:
  - rom_addr is held stable; the latency counter increments each clock.
  - When the counter reaches READ_LAT, latch rom_x/rom_y/rom_id into locx/locy/key_id, set out_valid=1, go to HOLD.
  - Timing: from the first FETCH cycle, out_valid rises exactly READ_LAT+1 clocks later.
- HOLD:
  - out_valid=1; outputs frozen until advance=1. advance is sampled only in HOLD.
  - advance=1 with index<DEPTH-1: index and rom_addr each increment by 1, counter=0, out_valid=0, go to FETCH.
  - advance=1 with index=DEPTH-1 and loop_en=1: index and rom_addr wrap to 0, go to FETCH.
  - advance=1 with index=DEPTH-1 and loop_en=0: out_valid=0, go to DONE.
  - loop_en is sampled at the advance cycle only.
- DONE:
  - done=1, held until start or clear.
  - start=1 → same as start from IDLE (done falls the next clock).
- start while busy is ignored.
- clear=1 in any state → next clock state=IDLE, out_valid=0, done=0, index=0, rom_addr=0. locx/locy/key_id keep their values.
- Simultaneous events:
  - clear with start → clear wins.
  - clear with advance → clear wins.
- Asynchronous reset mid-FETCH or mid-HOLD → reset values immediately; no pending entry survives.
- Width rules:
  - index/rom_addr arithmetic is AW-bit unsigned; the wrap compares against DEPTH-1, never relies on natural overflow.
  - Elaboration fails (generate-time check) if 2^AW < DEPTH or READ_LAT ∉ 1..4.
- Throughput: one entry per READ_LAT+2 clocks when advance is held high.

Decomposition:
- Shared package note_pkg:
  - key id constants KEY_A=0, KEY_S=1, KEY_D=2, KEY_F=3
  - state encoding localparams ST_IDLE, ST_FETCH, ST_HOLD, ST_DONE
  - default XW/YW/IDW values
- Natural sub-module: rom_lat_counter (0..READ_LAT counter with clear and terminal-count flag). Everything else stays in the top module.
- ROMs are instantiated by the parent, not inside this block.

Test Plan:
- Basic pass: DEPTH=4, READ_LAT=1, ROM X={10,20,30,40}, advance tied 1, start pulse → out_valid every 3 clocks carrying locx 10,20,30,40 and index 0..3; done=1 after the 4th accept.
- Latency alignment: READ_LAT=3, ROM X[i]=i, Y[i]=100+i, id[i]=i%4 → out_valid rises 4 clocks after FETCH entry; every presented triple matches the same index.
- Backpressure: hold advance=0 for 10 clocks at index 2 → locx/locy/key_id/index stable and out_valid=1 throughout; pulsing advance once moves to index 3.
- Loop wrap: DEPTH=4, loop_en=1 → index sequence 0,1,2,3,0,1, done never rises; drop loop_en before the next index-3 accept → DONE after that accept.
- Abort/priority: clear and start together in DONE → IDLE, done=0, no FETCH; clear and advance together in HOLD → IDLE, out_valid=0, index=0.
- Async reset mid-FETCH (index=2): assert reset between clock edges → all outputs at reset values immediately; start after release → pass restarts at index 0.
